// File: rtl/elink_pkg.sv
// Shared constants and helpers for the eLink receive path.
package elink_pkg;

  localparam int unsigned ELINK_LANES     = 8;
  localparam int unsigned ELINK_BYTE_W    = 8;
  localparam int unsigned ELINK_PKT_BYTES = 13;
  localparam int unsigned ELINK_LANE_W    = $clog2(ELINK_LANES);

  // Bit offset of byte lane k inside the 64-bit deserialised word.
  function automatic int unsigned lane_lsb(input int unsigned lane);
    return lane * ELINK_BYTE_W;
  endfunction

endpackage

// File: rtl/elink_rx_framer_if.sv
// Stream-in / packet-out bundle of the eLink receive framer.
interface elink_rx_framer_if
  import elink_pkg::*;
#(
  parameter int unsigned PKT_BYTES = ELINK_PKT_BYTES,
  parameter int unsigned CNT_W     = 16
);

  logic [ELINK_LANES*ELINK_BYTE_W-1:0] in_data;
  logic [ELINK_LANES-1:0]              in_mask;
  logic [PKT_BYTES*ELINK_BYTE_W-1:0]   pkt_data;
  logic                                pkt_valid;
  logic                                pkt_ready;
  logic                                err_trunc;
  logic                                err_ovf;
  logic [CNT_W-1:0]                    drop_cnt;

  modport master (
    input  in_data, in_mask, pkt_ready,
    output pkt_data, pkt_valid, err_trunc, err_ovf, drop_cnt
  );

  modport slave (
    output in_data, in_mask, pkt_ready,
    input  pkt_data, pkt_valid, err_trunc, err_ovf, drop_cnt
  );

endinterface

// File: rtl/elink_pkt_fifo.sv
// First-word-fall-through packet FIFO built as a shift register so the head is always entry 0.
module elink_pkt_fifo #(
  parameter int unsigned WIDTH = 104,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, n_mem;
  logic [DEPTH-1:0]            vld_q, n_vld;
  logic                        empty_q;

  // Pop shifts everything toward the head; an accepted push lands in the first free slot.
  always_comb begin
    logic placed;
    n_mem  = mem_q;
    n_vld  = vld_q;
    placed = 1'b0;
    if (pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        n_mem[i] = mem_q[i+1];
        n_vld[i] = vld_q[i+1];
      end
      n_vld[DEPTH-1] = 1'b0;
    end
    if (push && (!vld_q[DEPTH-1] || pop)) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (!n_vld[i] && !placed) begin
          n_mem[i] = push_data;
          n_vld[i] = 1'b1;
          placed   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      vld_q   <= '0;
      empty_q <= 1'b1;
    end else begin
      mem_q   <= n_mem;
      vld_q   <= n_vld;
      empty_q <= !n_vld[0];
    end
  end

  assign head_data = mem_q[0];
  assign full      = vld_q[DEPTH-1];
  assign empty     = empty_q;

endmodule

// File: rtl/elink_rx_framer.sv
// eLink receive framer: finds FRAME rises in the 8-lane stream, assembles fixed-size packets,
// buffers them for the transaction decoder and reports truncated / dropped packets.
module elink_rx_framer
  import elink_pkg::*;
#(
  parameter int unsigned PKT_BYTES  = ELINK_PKT_BYTES,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic                locked,
  elink_rx_framer_if.master   bus
);

  localparam int unsigned PKT_W = PKT_BYTES * ELINK_BYTE_W;
  localparam int unsigned CW    = $clog2(PKT_BYTES + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [CW-1:0]    count_q, next_count;
  logic             prev_frame_q, next_prev;
  logic [PKT_W-1:0] buf_q, next_buf, done_buf;
  logic             complete, trunc;
  logic             err_trunc_q, err_ovf_q;
  logic [CNT_W-1:0] drop_cnt_q, next_drop;
  logic [SUM_W-1:0] cnt_sum;
  logic [PKT_W-1:0] fifo_head;
  logic             fifo_full, fifo_empty, pop, ovf;

  // Lane scan, earliest lane (7) first, carrying count and prev_frame across lanes.
  always_comb begin : scan
    logic [CW-1:0]           c;
    logic                    pf;
    logic                    f;
    logic [ELINK_LANE_W-1:0] lane;
    logic [ELINK_BYTE_W-1:0] lane_byte;
    int unsigned             sh;
    c         = count_q;
    pf        = prev_frame_q;
    next_buf  = buf_q;
    done_buf  = '0;
    complete  = 1'b0;
    trunc     = 1'b0;
    f         = 1'b0;
    lane      = '0;
    lane_byte = '0;
    sh        = 0;
    for (int unsigned j = 0; j < ELINK_LANES; j++) begin
      lane      = ELINK_LANE_W'(ELINK_LANES - 1 - j);
      f         = bus.in_mask[lane];
      lane_byte = ELINK_BYTE_W'(bus.in_data >> lane_lsb(32'(lane)));
      sh        = (PKT_BYTES - 1 - 32'(c)) * ELINK_BYTE_W;
      if (c == '0) begin
        if (f && !pf) begin
          next_buf = (next_buf & ~(PKT_W'({ELINK_BYTE_W{1'b1}}) << sh)) | (PKT_W'(lane_byte) << sh);
          c        = CW'(1);
        end
      end else if (f) begin
        next_buf = (next_buf & ~(PKT_W'({ELINK_BYTE_W{1'b1}}) << sh)) | (PKT_W'(lane_byte) << sh);
        c        = c + CW'(1);
        if (c == CW'(PKT_BYTES)) begin
          complete = 1'b1;
          done_buf = next_buf;
          c        = '0;
        end
      end else begin
        trunc = 1'b1;
        c     = '0;
      end
      pf = f;
    end
    next_count = c;
    next_prev  = pf;
    // Loss of lock silently clears the assembler; a FRAME still high must fall before a new start.
    if (!locked) begin
      next_count = '0;
      next_prev  = 1'b1;
      complete   = 1'b0;
      trunc      = 1'b0;
    end
  end

  assign pop = bus.pkt_ready && !fifo_empty;
  assign ovf = complete && fifo_full && !pop;

  elink_pkt_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (pclk),
    .rst_n     (rst_n),
    .push      (complete),
    .push_data (done_buf),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Saturating drop counter fed by the registered error pulses.
  always_comb begin
    cnt_sum   = SUM_W'(drop_cnt_q) + SUM_W'(err_trunc_q) + SUM_W'(err_ovf_q);
    next_drop = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      prev_frame_q <= 1'b1;
      buf_q        <= '0;
      err_trunc_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      count_q      <= next_count;
      prev_frame_q <= next_prev;
      buf_q        <= next_buf;
      err_trunc_q  <= trunc;
      err_ovf_q    <= ovf;
      drop_cnt_q   <= next_drop;
    end
  end

  assign bus.pkt_data  = fifo_head;
  assign bus.pkt_valid = !fifo_empty;
  assign bus.err_trunc = err_trunc_q;
  assign bus.err_ovf   = err_ovf_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule
